// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory controller.
// Holds RV32I load/store width codes, controller states and default sizing.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int DEPTH_DEF    = 64;
  localparam int MAX_WAIT_DEF = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RMW_WR    = 2'd1,
    EXT_FORCE = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_ctrl_if.sv
// Bus bundle for dmem_ctrl: CPU port, external word port and memory port.
// slave is the controller's view; master is the environment (CPU, loader, memory).
interface dmem_ctrl_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [2:0]  cpu_funct3;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        cpu_err;

  logic        ext_req;
  logic        ext_we;
  logic [31:0] ext_addr;
  logic [31:0] ext_wdata;
  logic [31:0] ext_rdata;
  logic        ext_gnt;

  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  modport slave (
    input  cpu_req, cpu_we, cpu_funct3, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall, cpu_err,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    output ext_rdata, ext_gnt,
    output mem_we, mem_a, mem_wd,
    input  mem_rd
  );

  modport master (
    output cpu_req, cpu_we, cpu_funct3, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall, cpu_err,
    output ext_req, ext_we, ext_addr, ext_wdata,
    input  ext_rdata, ext_gnt,
    input  mem_we, mem_a, mem_wd,
    output mem_rd
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte/halfword lane logic: load extraction with sign/zero
// extension, and store merge of new lanes into an existing word.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{off, 3'b000} +: 8];
    half_sel = off[1] ? word[31:16] : word[15:0];

    case (funct3)
      F3_B:    load = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load = {24'h0, byte_sel};
      F3_H:    load = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load = {16'h0, half_sel};
      default: load = word;
    endcase

    // Stores only use the width bits; funct3[2] has no meaning for SB/SH.
    merged = word;
    case (funct3[1:0])
      2'b00: merged[{off, 3'b000} +: 8] = wdata[7:0];
      2'b01: begin
        if (off[1]) merged[31:16] = wdata[15:0];
        else        merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: RV32I sub-word loads/stores with a 2-cycle RMW,
// plus a shared external word port. DMEM_CTRL_EXT_FAIR_EN adds a forced grant.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
`ifdef DMEM_CTRL_EXT_FAIR_EN
  , parameter int MAX_WAIT = MAX_WAIT_DEF
`endif
) (
  input logic         clk,
  input logic         rst,
  dmem_ctrl_if.slave  bus
);

  state_t      state_q, state_d;
  logic [31:0] merge_q;
  logic [31:0] load_data, merged;
  logic        merge_en, ext_serve, misaligned, out_of_range, bad;

  logic [31:0] rdata, erdata, ma, mwd;
  logic        stall, err, gnt, mwe;

  dmem_lane_align u_align (
    .funct3 (bus.cpu_funct3),
    .off    (bus.cpu_addr[1:0]),
    .word   (bus.mem_rd),
    .wdata  (bus.cpu_wdata),
    .load   (load_data),
    .merged (merged)
  );

  always_comb begin
    case (bus.cpu_funct3)
      F3_H, F3_HU: misaligned = bus.cpu_addr[0];
      F3_W:        misaligned = |bus.cpu_addr[1:0];
      default:     misaligned = 1'b0;
    endcase
  end

  assign out_of_range = {2'b00, bus.cpu_addr[31:2]} >= 32'(DEPTH);
  assign bad          = misaligned | out_of_range;

`ifdef DMEM_CTRL_EXT_FAIR_EN
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  logic [CNT_W-1:0] wait_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                              wait_q <= '0;
    else if (gnt)                                          wait_q <= '0;
    else if (bus.ext_req && (wait_q < CNT_W'(MAX_WAIT)))   wait_q <= wait_q + CNT_W'(1);
  end
`endif

  always_comb begin
    state_d   = state_q;
    merge_en  = 1'b0;
    ext_serve = 1'b0;
    rdata     = '0;
    erdata    = '0;
    stall     = 1'b0;
    err       = 1'b0;
    gnt       = 1'b0;
    mwe       = 1'b0;
    ma        = bus.cpu_addr;
    mwd       = bus.cpu_wdata;

    case (state_q)
      IDLE: begin
        if (bus.cpu_req) begin
          if (bad)                       err = 1'b1;
          else if (!bus.cpu_we)          rdata = load_data;
          else if (bus.cpu_funct3 == F3_W) mwe = 1'b1;
          else begin
            // Read phase of SB/SH: capture the merged word, write next cycle.
            stall    = 1'b1;
            merge_en = 1'b1;
            state_d  = RMW_WR;
          end
        end else if (bus.ext_req) begin
          ext_serve = 1'b1;
        end
      end
      RMW_WR: begin
        mwe     = 1'b1;
        mwd     = merge_q;
        state_d = IDLE;
      end
`ifdef DMEM_CTRL_EXT_FAIR_EN
      EXT_FORCE: begin
        ext_serve = 1'b1;
        stall     = 1'b1;
        state_d   = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase

    if (ext_serve) begin
      gnt    = 1'b1;
      ma     = bus.ext_addr;
      mwe    = bus.ext_we;
      mwd    = bus.ext_wdata;
      erdata = bus.mem_rd;
    end

`ifdef DMEM_CTRL_EXT_FAIR_EN
    // The wait that reaches MAX_WAIT this cycle forces the grant next cycle,
    // unless an RMW is starting, in which case it is honoured after RMW_WR.
    if (bus.ext_req && !ext_serve && (wait_q >= CNT_W'(MAX_WAIT - 1)) && (state_d != RMW_WR))
      state_d = EXT_FORCE;
`endif

    if (!rst) begin
      merge_en = 1'b0;
      stall    = 1'b0;
      err      = 1'b0;
      gnt      = 1'b0;
      mwe      = 1'b0;
      erdata   = '0;
      rdata    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (merge_en) merge_q <= merged;
  end

  assign bus.cpu_rdata = rdata;
  assign bus.cpu_stall = stall;
  assign bus.cpu_err   = err;
  assign bus.ext_rdata = erdata;
  assign bus.ext_gnt   = gnt;
  assign bus.mem_we    = mwe;
  assign bus.mem_a     = ma;
  assign bus.mem_wd    = mwd;

endmodule
